// File: rtl/stack_alu_ctrl_pkg.sv
// Shared types for the stack ALU controller: opcodes, FSM states, error codes
// and the default data-stack depth.
package stack_pkg;

    localparam int DEPTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_DUP  = 3'd3,
        OP_BIN  = 3'd4,
        OP_UNA  = 3'd5,
        OP_SWAP = 3'd6,
        OP_CLR  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPND = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_UNDERFLOW  = 2'd1,
        ERR_OVERFLOW   = 2'd2,
        ERR_ILLEGAL_FN = 2'd3
    } err_e;

    localparam logic [2:0] UNA_FN_MAX = 3'd2;

    // Number of stack entries an opcode must find before it may run.
    function automatic logic [1:0] operand_need(op_e op);
        case (op)
            OP_BIN, OP_SWAP:        operand_need = 2'd2;
            OP_UNA, OP_POP, OP_DUP: operand_need = 2'd1;
            default:                operand_need = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stack_alu_ctrl_if.sv
// Command handshake and external-ALU signals between the controller (slave)
// and the host that issues commands and supplies the ALU (master).
interface stack_alu_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_fn;
    logic [7:0] cmd_imm;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_fn_sel;
    logic       alu_arg_cnt;
    logic [7:0] alu_q;

    modport master (
        output cmd_valid, cmd_op, cmd_fn, cmd_imm, alu_q,
        input  cmd_ready, done, err, err_code,
               alu_a, alu_b, alu_fn_sel, alu_arg_cnt
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_fn, cmd_imm, alu_q,
        output cmd_ready, done, err, err_code,
               alu_a, alu_b, alu_fn_sel, alu_arg_cnt
    );

endinterface

// File: rtl/stack_regfile.sv
// Data-stack storage: reads the two topmost entries combinationally, with one
// write port and a swap strobe that exchanges the top two entries in one edge.
module stack_regfile #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic [$clog2(DEPTH)-1:0]   sp_lo,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [7:0]                 wr_data,
    input  logic                       swap_en,
    output logic [7:0]                 rd_top,
    output logic [7:0]                 rd_next
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] idx_top;
    logic [AW-1:0] idx_next;

    // Pointer arithmetic wraps modulo DEPTH, so a full stack (low bits 0) still
    // addresses its topmost entries correctly.
    assign idx_top  = sp_lo - AW'(1);
    assign idx_next = sp_lo - AW'(2);

    assign rd_top  = mem[idx_top];
    assign rd_next = mem[idx_next];

    always_ff @(posedge clk) begin
        if (swap_en) begin
            mem[idx_top]  <= mem[idx_next];
            mem[idx_next] <= mem[idx_top];
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/stack_alu_ctrl.sv
// Stack-machine controller: accepts commands, checks them, sequences operands
// through an external combinational ALU and owns the stack pointer.
module stack_alu_ctrl
    import stack_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    stack_alu_ctrl_if.slave          bus,
    output logic [7:0]               top,
    output logic [$clog2(DEPTH):0]   depth
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;
    localparam logic [SW-1:0] SP_FULL = SW'(DEPTH);

    state_e        state;
    op_e           op_q;
    err_e          err_q;
    logic [7:0]    imm_q;
    logic [7:0]    q_q;
    logic [SW-1:0] sp;
    logic [AW-1:0] sp_lo;

    logic          done_r;
    logic          err_r;
    err_e          err_code_r;
    logic [7:0]    alu_a_r;
    logic [7:0]    alu_b_r;
    logic [2:0]    alu_fn_r;
    logic          alu_cnt_r;

    op_e           cmd_op_e;
    err_e          chk_code;
    logic          cmd_is_alu;
    logic          cmd_is_bin;

    logic [7:0]    rd_top;
    logic [7:0]    rd_next;
    logic          wr_en;
    logic          swap_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    assign sp_lo      = sp[AW-1:0];
    assign cmd_op_e   = op_e'(bus.cmd_op);
    assign cmd_is_bin = (cmd_op_e == OP_BIN);
    assign cmd_is_alu = cmd_is_bin || (cmd_op_e == OP_UNA);

    stack_regfile #(
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .sp_lo   (sp_lo),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .swap_en (swap_en),
        .rd_top  (rd_top),
        .rd_next (rd_next)
    );

    // Accept-time checks, highest priority first: illegal fn, underflow, overflow.
    always_comb begin
        chk_code = ERR_NONE;
        if (cmd_op_e == OP_UNA && bus.cmd_fn > UNA_FN_MAX) begin
            chk_code = ERR_ILLEGAL_FN;
        end else if (sp < SW'(operand_need(cmd_op_e))) begin
            chk_code = ERR_UNDERFLOW;
        end else if ((cmd_op_e == OP_PUSH || cmd_op_e == OP_DUP) && sp == SP_FULL) begin
            chk_code = ERR_OVERFLOW;
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        swap_en = 1'b0;
        wr_addr = sp_lo;
        wr_data = imm_q;
        if (state == WB && err_q == ERR_NONE) begin
            case (op_q)
                OP_BIN: begin
                    wr_en   = 1'b1;
                    wr_addr = sp_lo - AW'(2);
                    wr_data = q_q;
                end
                OP_UNA: begin
                    wr_en   = 1'b1;
                    wr_addr = sp_lo - AW'(1);
                    wr_data = q_q;
                end
                OP_PUSH: wr_en = 1'b1;
                OP_DUP: begin
                    wr_en   = 1'b1;
                    wr_data = rd_top;
                end
                OP_SWAP: swap_en = 1'b1;
                default: ;
            endcase
        end
    end

    // Rejected commands skip straight to WB so they complete in one cycle and
    // leave both sp and the storage untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sp         <= '0;
            op_q       <= OP_NOP;
            err_q      <= ERR_NONE;
            imm_q      <= '0;
            q_q        <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
            alu_a_r    <= '0;
            alu_b_r    <= '0;
            alu_fn_r   <= '0;
            alu_cnt_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q  <= cmd_op_e;
                        imm_q <= bus.cmd_imm;
                        err_q <= chk_code;
                        if (chk_code == ERR_NONE && cmd_is_alu) begin
                            alu_a_r   <= cmd_is_bin ? rd_next : rd_top;
                            alu_b_r   <= cmd_is_bin ? rd_top : 8'h00;
                            alu_fn_r  <= bus.cmd_fn;
                            alu_cnt_r <= cmd_is_bin;
                            state     <= OPND;
                        end else begin
                            state <= WB;
                        end
                    end
                end
                OPND: state <= EXEC;
                EXEC: begin
                    q_q   <= bus.alu_q;
                    state <= WB;
                end
                WB: begin
                    done_r     <= 1'b1;
                    err_r      <= (err_q != ERR_NONE);
                    err_code_r <= err_q;
                    if (err_q == ERR_NONE) begin
                        case (op_q)
                            OP_BIN, OP_POP:  sp <= sp - SW'(1);
                            OP_PUSH, OP_DUP: sp <= sp + SW'(1);
                            OP_CLR:          sp <= '0;
                            default: ;
                        endcase
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.done        = done_r;
    assign bus.err         = err_r;
    assign bus.err_code    = err_code_r;
    assign bus.alu_a       = alu_a_r;
    assign bus.alu_b       = alu_b_r;
    assign bus.alu_fn_sel  = alu_fn_r;
    assign bus.alu_arg_cnt = alu_cnt_r;

    assign top   = (sp == '0) ? 8'h00 : rd_top;
    assign depth = sp;

endmodule

// File: tb/tb_stack_alu_ctrl.sv
// Self-checking bench for stack_alu_ctrl: directed vector table, hand-written
// corner sequences and randomized commands against a queue-based stack model.
module tb_stack_alu_ctrl;
    import stack_pkg::*;

    localparam int DEPTH = 8;

    logic                    clk;
    logic                    rst_n;
    logic [7:0]              top;
    logic [$clog2(DEPTH):0]  depth;

    int checks = 0;
    int errors = 0;

    logic [7:0] mstack[$];

    stack_alu_ctrl_if bus ();

    stack_alu_ctrl #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .top   (top),
        .depth (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bin_ref(logic [2:0] fn, logic [7:0] a, logic [7:0] b);
        case (fn)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[2:0];
            3'd6:    return a >> b[2:0];
            default: return a * b;
        endcase
    endfunction

    function automatic logic [7:0] una_ref(logic [2:0] fn, logic [7:0] a);
        case (fn)
            3'd0:    return a;
            3'd1:    return ~a;
            3'd2:    return 8'h00 - a;
            default: return 8'h00;
        endcase
    endfunction

    // The external ALU the controller drives.
    always_comb begin
        bus.alu_q = bus.alu_arg_cnt ? bin_ref(bus.alu_fn_sel, bus.alu_a, bus.alu_b)
                                    : una_ref(bus.alu_fn_sel, bus.alu_a);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] fn, input logic [7:0] imm,
                                 output int lat, output logic got_err, output logic [1:0] got_code,
                                 output logic [7:0] opnd_a, output logic [7:0] opnd_b,
                                 output logic [2:0] opnd_fn, output logic opnd_cnt,
                                 output logic opnd_stable);
        int wait_cnt;
        wait_cnt = 0;
        while (!bus.cmd_ready && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        if (!bus.cmd_ready) checkOutput("ready_timeout", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_fn    = fn;
        bus.cmd_imm   = imm;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom());
        bus.cmd_fn    = 3'($urandom());
        bus.cmd_imm   = 8'($urandom());
        opnd_a      = bus.alu_a;
        opnd_b      = bus.alu_b;
        opnd_fn     = bus.alu_fn_sel;
        opnd_cnt    = bus.alu_arg_cnt;
        opnd_stable = 1'b1;
        lat         = 99;
        got_err     = 1'b0;
        got_code    = 2'd0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1 && (bus.alu_a !== opnd_a || bus.alu_b !== opnd_b ||
                           bus.alu_fn_sel !== opnd_fn || bus.alu_arg_cnt !== opnd_cnt))
                opnd_stable = 1'b0;
            if (bus.done) begin
                lat      = k;
                got_err  = bus.err;
                got_code = bus.err_code;
                break;
            end
        end
    endtask

    // Reference model: a queue whose back is the top of stack.
    task automatic modelCmd(input logic [2:0] op, input logic [2:0] fn, input logic [7:0] imm,
                            output int exp_lat, output logic [1:0] exp_code,
                            output logic [7:0] exp_a, output logic [7:0] exp_b);
        int need;
        int n;
        logic [7:0] x;
        logic [7:0] y;
        n = mstack.size();
        need = (op == OP_BIN || op == OP_SWAP) ? 2 :
               (op == OP_UNA || op == OP_POP || op == OP_DUP) ? 1 : 0;
        if (op == OP_UNA && fn > 3'd2)                           exp_code = 2'd3;
        else if (n < need)                                       exp_code = 2'd1;
        else if ((op == OP_PUSH || op == OP_DUP) && n == DEPTH)  exp_code = 2'd2;
        else                                                     exp_code = 2'd0;
        exp_lat = (exp_code == 2'd0 && (op == OP_BIN || op == OP_UNA)) ? 3 : 1;
        exp_a = 8'h00;
        exp_b = 8'h00;
        if (exp_code == 2'd0) begin
            case (op)
                OP_BIN: begin
                    y = mstack.pop_back();
                    x = mstack.pop_back();
                    exp_a = x;
                    exp_b = y;
                    mstack.push_back(bin_ref(fn, x, y));
                end
                OP_UNA: begin
                    x = mstack.pop_back();
                    exp_a = x;
                    mstack.push_back(una_ref(fn, x));
                end
                OP_PUSH: mstack.push_back(imm);
                OP_POP:  void'(mstack.pop_back());
                OP_DUP:  mstack.push_back(mstack[$]);
                OP_SWAP: begin
                    y = mstack.pop_back();
                    x = mstack.pop_back();
                    mstack.push_back(y);
                    mstack.push_back(x);
                end
                OP_CLR:  mstack.delete();
                default: ;
            endcase
        end
    endtask

    task automatic runCmd(input string tag, input logic [2:0] op, input logic [2:0] fn, input logic [7:0] imm);
        int exp_lat, lat;
        logic [1:0] exp_code, got_code;
        logic [7:0] exp_a, exp_b, oa, ob, exp_top;
        logic got_err, ocnt, ostable;
        logic [2:0] ofn;
        modelCmd(op, fn, imm, exp_lat, exp_code, exp_a, exp_b);
        applyStimulus(op, fn, imm, lat, got_err, got_code, oa, ob, ofn, ocnt, ostable);
        exp_top = (mstack.size() == 0) ? 8'h00 : mstack[$];
        checkOutput({tag, ".lat"},   32'(lat),      32'(exp_lat));
        checkOutput({tag, ".err"},   32'(got_err),  32'(exp_code != 2'd0));
        checkOutput({tag, ".code"},  32'(got_code), 32'(exp_code));
        checkOutput({tag, ".top"},   32'(top),      32'(exp_top));
        checkOutput({tag, ".depth"}, 32'(depth),    32'(mstack.size()));
        if (exp_code == 2'd0 && (op == OP_BIN || op == OP_UNA)) begin
            checkOutput({tag, ".alu_a"},  32'(oa),      32'(exp_a));
            checkOutput({tag, ".alu_b"},  32'(ob),      32'(exp_b));
            checkOutput({tag, ".fn_sel"}, 32'(ofn),     32'(fn));
            checkOutput({tag, ".argcnt"}, 32'(ocnt),    32'(op == OP_BIN));
            checkOutput({tag, ".stable"}, 32'(ostable), 32'd1);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [2:0] fn;
        logic [7:0] imm;
        logic [7:0] exp_top;
        int         exp_depth;
        logic [1:0] exp_code;
        int         exp_lat;
    } vec_t;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[20];
        int lat, acc, dones, cyc;
        logic got_err, rp, ocnt, ostable;
        logic [1:0] got_code;
        logic [7:0] oa, ob, va, vb;
        logic [2:0] ofn;
        logic [2:0] seq_op[3];
        logic [7:0] seq_imm[3];
        logic [2:0] rop, rfn;
        int r;

        vecs[0]  = '{OP_PUSH, 3'd0, 8'h05, 8'h05, 1, 2'd0, 1};
        vecs[1]  = '{OP_PUSH, 3'd0, 8'h03, 8'h03, 2, 2'd0, 1};
        vecs[2]  = '{OP_BIN,  3'd1, 8'h00, 8'h02, 1, 2'd0, 3};
        vecs[3]  = '{OP_BIN,  3'd0, 8'h00, 8'h02, 1, 2'd1, 1};
        vecs[4]  = '{OP_UNA,  3'd3, 8'h00, 8'h02, 1, 2'd3, 1};
        vecs[5]  = '{OP_POP,  3'd0, 8'h00, 8'h00, 0, 2'd0, 1};
        vecs[6]  = '{OP_POP,  3'd0, 8'h00, 8'h00, 0, 2'd1, 1};
        vecs[7]  = '{OP_UNA,  3'd5, 8'h00, 8'h00, 0, 2'd3, 1};
        vecs[8]  = '{OP_CLR,  3'd0, 8'h00, 8'h00, 0, 2'd0, 1};
        vecs[9]  = '{OP_PUSH, 3'd0, 8'h80, 8'h80, 1, 2'd0, 1};
        vecs[10] = '{OP_UNA,  3'd2, 8'h00, 8'h80, 1, 2'd0, 3};
        vecs[11] = '{OP_PUSH, 3'd0, 8'h0F, 8'h0F, 2, 2'd0, 1};
        vecs[12] = '{OP_UNA,  3'd1, 8'h00, 8'hF0, 2, 2'd0, 3};
        vecs[13] = '{OP_SWAP, 3'd0, 8'h00, 8'h80, 2, 2'd0, 1};
        vecs[14] = '{OP_DUP,  3'd0, 8'h00, 8'h80, 3, 2'd0, 1};
        vecs[15] = '{OP_BIN,  3'd4, 8'h00, 8'h00, 2, 2'd0, 3};
        vecs[16] = '{OP_SWAP, 3'd0, 8'h00, 8'hF0, 2, 2'd0, 1};
        vecs[17] = '{OP_NOP,  3'd0, 8'h00, 8'hF0, 2, 2'd0, 1};
        vecs[18] = '{OP_CLR,  3'd0, 8'h00, 8'h00, 0, 2'd0, 1};
        vecs[19] = '{OP_SWAP, 3'd0, 8'h00, 8'h00, 0, 2'd1, 1};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_fn    = 3'd0;
        bus.cmd_imm   = 8'h00;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.done",     32'(bus.done),        32'd0);
        checkOutput("rst.err",      32'(bus.err),         32'd0);
        checkOutput("rst.err_code", 32'(bus.err_code),    32'd0);
        checkOutput("rst.alu_a",    32'(bus.alu_a),       32'd0);
        checkOutput("rst.alu_b",    32'(bus.alu_b),       32'd0);
        checkOutput("rst.fn_sel",   32'(bus.alu_fn_sel),  32'd0);
        checkOutput("rst.argcnt",   32'(bus.alu_arg_cnt), 32'd0);
        checkOutput("rst.depth",    32'(depth),           32'd0);
        checkOutput("rst.top",      32'(top),             32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst.ready", 32'(bus.cmd_ready), 32'd1);

        $display("[TB] directed vector table");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].op, vecs[i].fn, vecs[i].imm, lat, got_err, got_code,
                          oa, ob, ofn, ocnt, ostable);
            checkOutput($sformatf("vec%0d.lat", i),   32'(lat),      32'(vecs[i].exp_lat));
            checkOutput($sformatf("vec%0d.err", i),   32'(got_err),  32'(vecs[i].exp_code != 2'd0));
            checkOutput($sformatf("vec%0d.code", i),  32'(got_code), 32'(vecs[i].exp_code));
            checkOutput($sformatf("vec%0d.top", i),   32'(top),      32'(vecs[i].exp_top));
            checkOutput($sformatf("vec%0d.depth", i), 32'(depth),    32'(vecs[i].exp_depth));
        end

        $display("[TB] overflow then BIN on a full stack");
        mstack.delete();
        for (int i = 0; i < DEPTH; i++) runCmd($sformatf("fill%0d", i), OP_PUSH, 3'd0, 8'(i + 1));
        runCmd("ovf_push", OP_PUSH, 3'd0, 8'hAA);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("ovf.code_held", 32'(bus.err_code), 32'd2);
        checkOutput("ovf.err_pulse", 32'(bus.err),      32'd0);
        runCmd("ovf_dup", OP_DUP, 3'd0, 8'h00);
        runCmd("full_bin", OP_BIN, 3'd0, 8'h00);
        checkOutput("full_bin.top", 32'(top), 32'd15);

        $display("[TB] reset during EXEC");
        runCmd("pre_rst_push", OP_PUSH, 3'd0, 8'h21);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_BIN;
        bus.cmd_fn    = 3'd0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.depth", 32'(depth),         32'd0);
        checkOutput("midrst.done",  32'(bus.done),      32'd0);
        mstack.delete();
        dones = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst.ready", 32'(bus.cmd_ready), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        checkOutput("midrst.no_done", 32'(dones), 32'd0);
        checkOutput("midrst.top",     32'(top),   32'd0);

        $display("[TB] back-to-back commands with valid held high");
        va = 8'($urandom());
        vb = ~va;
        seq_op[0] = OP_PUSH; seq_imm[0] = va;
        seq_op[1] = OP_PUSH; seq_imm[1] = vb;
        seq_op[2] = OP_SWAP; seq_imm[2] = 8'h00;
        acc = 0;
        dones = 0;
        cyc = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = seq_op[0];
        bus.cmd_fn    = 3'd0;
        bus.cmd_imm   = seq_imm[0];
        while (acc < 3 && cyc < 30) begin
            rp = bus.cmd_ready;
            @(posedge clk); #1;
            cyc++;
            if (bus.done) dones++;
            if (rp) begin
                acc++;
                if (acc < 3) begin
                    bus.cmd_op  = seq_op[acc];
                    bus.cmd_imm = seq_imm[acc];
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
        end
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        checkOutput("b2b.accepts", 32'(acc),   32'd3);
        checkOutput("b2b.cycles",  32'(cyc),   32'd5);
        checkOutput("b2b.dones",   32'(dones), 32'd3);
        checkOutput("b2b.top",     32'(top),   32'(va));
        checkOutput("b2b.depth",   32'(depth), 32'd2);
        mstack.push_back(vb);
        mstack.push_back(va);

        $display("[TB] randomized commands");
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      rop = OP_PUSH;
            else if (r < 44) rop = OP_BIN;
            else if (r < 56) rop = OP_UNA;
            else if (r < 66) rop = OP_POP;
            else if (r < 74) rop = OP_DUP;
            else if (r < 84) rop = OP_SWAP;
            else if (r < 87) rop = OP_CLR;
            else             rop = 3'($urandom());
            rfn = (rop == OP_UNA) ? 3'($urandom_range(0, 3)) : 3'($urandom());
            runCmd($sformatf("rnd%0d", i), rop, rfn, 8'($urandom()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_alu_ctrl.md
STACK_ALU_CTRL -- requirements
Module: stack_alu_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning data-stack entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, exposed as the ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_op  input  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 BIN, 5 UNA, 6 SWAP, 7 CLR.
REQ-008 cmd_fn  input  3  ALU function; binary 0..7, unary 0 pass, 1 not, 2 neg.
REQ-009 cmd_imm  input  8  PUSH operand.
REQ-010 alu_a, alu_b  output  8 each  ALU operands.
REQ-011 alu_fn_sel  output  3  ALU function select.
REQ-012 alu_arg_cnt  output  1  1 = binary, 0 = unary.
REQ-013 alu_q  input  8  combinational ALU result.
REQ-014 done  output  1  one-cycle pulse at command completion.
REQ-015 err  output  1  one-cycle pulse, coincident with done, on a rejected command.
REQ-016 err_code  output  2  0 none, 1 underflow, 2 overflow, 3 illegal fn; held until the next done.
REQ-017 top  output  8  current top of stack, or 0 when the stack is empty.
REQ-018 depth  output  log2(DEPTH)+1  current entry count.

Function
REQ-019 The FSM SHALL use the states IDLE, OPND, EXEC and WB; cmd_ready SHALL be 1 only in IDLE.
REQ-020 A command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both 1; cmd_op, cmd_fn and cmd_imm SHALL be latched on that edge.
REQ-021 BIN and UNA SHALL sequence IDLE->OPND->EXEC->WB->IDLE; all other ops SHALL sequence IDLE->WB->IDLE.
REQ-022 Command latency SHALL be: accept at edge N; done at N+3 for ALU ops and N+1 for other ops; cmd_ready high again the cycle after done.
REQ-023 In OPND, BIN SHALL latch alu_a = entry[sp-2] and alu_b = entry[sp-1]; UNA SHALL latch alu_a = entry[sp-1] and alu_b = 0.
REQ-024 alu_a, alu_b, alu_fn_sel and alu_arg_cnt SHALL be registered and stable from OPND through EXEC.
REQ-025 alu_q SHALL be sampled at the end of EXEC.
REQ-026 In WB, the data-stack update SHALL be:
- BIN: pop 2, push q (sp-1).
- UNA: replace top with q.
- PUSH: push imm.
- POP: sp-1.
- DUP: push top.
- SWAP: exchange the top two entries.
- CLR: sp=0.
- NOP: no change.
REQ-027 Underflow SHALL be detected when sp is less than the operand need (BIN 2, UNA 1, POP 1, DUP 1, SWAP 2).
REQ-028 Overflow SHALL be detected on PUSH or DUP with sp=DEPTH.
REQ-029 Illegal fn SHALL be detected on UNA with cmd_fn>2.
REQ-030 Error checks SHALL be made at accept; any error SHALL route IDLE->WB and leave the stack untouched.
REQ-031 Check priority SHALL be illegal fn > underflow > overflow.
REQ-032 Arithmetic SHALL be 8-bit with wrap; the block SHALL add no carry or flags.
REQ-033 When sp=DEPTH and a BIN executes, the resulting sp=DEPTH-1 SHALL be legal.
REQ-034 CLR on an empty stack SHALL be a non-error.
REQ-035 cmd_valid outside IDLE SHALL be ignored, and its command SHALL not be consumed.

Reset
REQ-036 On rst_n low, asynchronously: state=IDLE, sp=0, done=0, err=0, err_code=0, alu_a=alu_b=0, alu_fn_sel=0, alu_arg_cnt=0.
REQ-037 Reset mid-command SHALL abort the command with no done pulse.
REQ-038 cmd_ready SHALL be 1 in the first cycle after reset release.
REQ-039 Stack entry contents are not reset; they SHALL be unobservable while sp=0.

Structure
REQ-040 A shared package stack_pkg SHALL hold the opcode enum, the FSM state enum, the err_code enum and the DEPTH default.
REQ-041 The stack storage SHALL be the sub-module stack_regfile: two combinational read ports (top, top-1), one write port and a swap strobe.
REQ-042 The FSM and sp logic SHALL reside in stack_alu_ctrl.

Verification
REQ-043 PUSH 5, PUSH 3, BIN fn=1 -> done at accept+3, top=2, depth=1, err=0.
REQ-044 PUSH 0x80, UNA fn=2 -> top=0x80 (wrap), depth=1; UNA fn=1 on 0x0F -> top=0xF0.
REQ-045 BIN with depth=1 -> done plus err at accept+1, err_code=1, depth=1, top unchanged.
REQ-046 DEPTH PUSHes, then PUSH 0xAA -> err_code=2, depth=DEPTH; then BIN fn=0 -> depth=DEPTH-1, no err.
REQ-047 rst_n low during EXEC of a BIN -> no done pulse, depth=0, cmd_ready=1 after release.
REQ-048 cmd_valid held high continuously with back-to-back PUSH, PUSH, SWAP -> exactly three accepts, top equals the first pushed value.
